// File: rtl/prio_enc_arb.sv
// prio_enc_arb: N-input priority encoder with registered outputs, a
// grant/acknowledge handshake and an optional round-robin mode.
// A winner is picked only in IDLE. The grant is then held unchanged until
// the consumer acknowledges it, and one IDLE cycle always follows each grant.
module prio_enc_arb #(
    parameter int N     = 4,
    parameter int RR_EN = 1,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] grant
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [W-1:0] PTR_TOP = W'(N - 1);
    localparam logic [N-1:0] ONE_HOT = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   code_q,  code_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [W-1:0]   ptr_q,   ptr_d;

    logic [W-1:0]   fixed_win;
    logic [W-1:0]   rr_win;
    logic [W-1:0]   win;
    logic           rr_active;

    assign rr_active = (RR_EN != 0) && mode;
    assign win       = rr_active ? rr_win : fixed_win;

    // Fixed priority: the highest set request index wins.
    always_comb begin
        fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_win = W'(i);
            end
        end
    end

    // Round robin: first set request found searching downward from ptr, wrapping from 0 to N-1.
    always_comb begin
        int  idx;
        logic found;
        rr_win = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) - k;
            if (idx < 0) begin
                idx = idx + N;
            end
            if (!found && req[idx]) begin
                rr_win = W'(idx);
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; the outputs themselves are registered below.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    code_d  = win;
                    grant_d = ONE_HOT << win;
                end else begin
                    valid_d = 1'b0;
                    code_d  = '0;
                    grant_d = '0;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    code_d  = '0;
                    grant_d = '0;
                    if (rr_active) begin
                        ptr_d = (code_q == '0) ? PTR_TOP : (code_q - W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                code_d  = '0;
                grant_d = '0;
            end
        endcase
    end

    // State, output and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
            grant_q <= '0;
            ptr_q   <= PTR_TOP;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid = valid_q;
    assign code  = code_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: directed test of prio_enc_arb (N=4, RR_EN=1) using
// hand-computed expected outputs and immediate assertions.
module tb_prio_enc_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mode;
    logic       ack;
    logic       valid;
    logic [1:0] code;
    logic [3:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    prio_enc_arb #(.N(4), .RR_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .mode  (mode),
        .ack   (ack),
        .valid (valid),
        .code  (code),
        .grant (grant)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, then advance one rising edge and settle 1 unit past it.
    task automatic applyStimulus(input logic r_n, input logic [3:0] r,
                                 input logic m, input logic a);
        rst_n = r_n;
        req   = r;
        mode  = m;
        ack   = a;
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against expected values and check the grant invariants.
    task automatic checkOutput(input string tag, input logic ev,
                               input logic [1:0] ec, input logic [3:0] eg);
        logic inv_ok;
        n_checks++;
        assert (valid === ev) else begin
            n_fail++;
            $error("[TB] FAIL %s valid: got %0b expected %0b", tag, valid, ev);
        end
        n_checks++;
        assert (code === ec) else begin
            n_fail++;
            $error("[TB] FAIL %s code: got %0d expected %0d", tag, code, ec);
        end
        n_checks++;
        assert (grant === eg) else begin
            n_fail++;
            $error("[TB] FAIL %s grant: got %b expected %b", tag, grant, eg);
        end
        inv_ok = valid ? ($onehot(grant) && grant[code]) : (grant == 4'b0000);
        n_checks++;
        assert (inv_ok === 1'b1) else begin
            n_fail++;
            $error("[TB] FAIL %s invariant: valid=%0b code=%0d grant=%b", tag, valid, code, grant);
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

        rst_n = 1'b0;
        req   = 4'b1111;
        mode  = 1'b0;
        ack   = 1'b0;

        // Reset held for two edges with all requests active.
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        checkOutput("reset_edge1", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        checkOutput("reset_edge2", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
        checkOutput("reset_release", 1'b1, 2'd3, 4'b1000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput("reset_ack", 1'b0, 2'd0, 4'b0000);

        // Fixed priority with varied request patterns.
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
        checkOutput("fixed_0001", 1'b1, 2'd0, 4'b0001);
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b1);
        checkOutput("fixed_ack_wins", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0);
        checkOutput("fixed_0110", 1'b1, 2'd2, 4'b0100);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1);
        checkOutput("fixed_ack2", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
        checkOutput("fixed_0010", 1'b1, 2'd1, 4'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput("fixed_ack3", 1'b0, 2'd0, 4'b0000);

        // Ack while idle has no effect.
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput("idle_ack_ignored", 1'b0, 2'd0, 4'b0000);

        // Fixed priority starves lower requests.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
            checkOutput($sformatf("starve_grant%0d", i), 1'b1, 2'd3, 4'b1000);
            applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
            checkOutput($sformatf("starve_ack%0d", i), 1'b0, 2'd0, 4'b0000);
        end

        // Round robin rotates downward from ptr=3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
            checkOutput($sformatf("rr_grant%0d", i), 1'b1, rr_seq[i], 4'b0001 << rr_seq[i]);
            applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
            checkOutput($sformatf("rr_ack%0d", i), 1'b0, 2'd0, 4'b0000);
        end
        // ptr is now 2: search 2,1,0 finds request 0, then wraps to 3.
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0);
        checkOutput("rr_1001_a", 1'b1, 2'd0, 4'b0001);
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1);
        checkOutput("rr_1001_ack_a", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0);
        checkOutput("rr_1001_b", 1'b1, 2'd3, 4'b1000);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
        checkOutput("rr_1001_ack_b", 1'b0, 2'd0, 4'b0000);

        // Sticky grant survives request changes until ack.
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
        checkOutput("sticky_grant", 1'b1, 2'd2, 4'b0100);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("sticky_req_drop", 1'b1, 2'd2, 4'b0100);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
        checkOutput("sticky_req_change", 1'b1, 2'd2, 4'b0100);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
        checkOutput("sticky_ack", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
        checkOutput("sticky_next", 1'b1, 2'd3, 4'b1000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput("sticky_next_ack", 1'b0, 2'd0, 4'b0000);

        // Mid-grant reset in round-robin mode restores ptr to 3.
        applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0);
        checkOutput("midrst_grant", 1'b1, 2'd1, 4'b0010);
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
        checkOutput("midrst_reset", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("midrst_release", 1'b1, 2'd3, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
